sdram_bridge_arbiter: RTL and testbench

Shares the SoC's single Avalon bridge port into SDRAM between two requesters: the SD-card loader (word writes) and the playback fetch path (word reads). It sits between those engines and the `avalon_bridge_*` pins of the SoC. It serialises their transactions, converts word addresses to byte addresses, guards against a hung bus with a timeout, and gives reads priority with a bounded-starvation guarantee for writes.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_bridge_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sdram_bridge_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM bridge arbiter.
package sdram_arb_pkg;

    // Arbiter states; the encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // The bridge is always driven with full 16-bit words.
    localparam logic [1:0] ARB_BYTE_EN = 2'b11;

    // Default requester word-address and data widths.
    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/sdram_bridge_arbiter.sv
// Two-requester arbiter in front of the SoC's Avalon bridge into SDRAM.
// The loader writes words and the playback path reads words. Reads have
// priority, but a pending write is granted after MAX_RD_STREAK reads in a row.
//
// Handshake: a requester raises *_req together with its address and data and
// holds all of them until its completion pulse (wr_ack / rd_valid). The
// request is sampled only in IDLE. Once granted, the transaction is committed:
// dropping or changing the request has no effect until the pulse. On the
// bridge side the strobe, address and write data stay constant until a
// single-cycle bus_acknowledge. If no acknowledge arrives within TIMEOUT_CYC
// busy cycles, the transaction is abandoned, bus_err latches, and the
// requester still receives its pulse (rd_data = 0 for a read).
module sdram_bridge_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MAX_RD_STREAK = 8,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   bus_address,
    output logic [1:0]        bus_byte_enable,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic              bus_acknowledge,
    input  logic [DATA_W-1:0] bus_read_data,
    output logic              busy,
    output logic              bus_err,
    output arb_state_t        dbg_state
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int ST_W = $clog2(MAX_RD_STREAK + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(MAX_RD_STREAK);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ST_W-1:0]   r_rd_streak;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ADDR_W:0]   r_bus_address;
    logic [DATA_W-1:0] r_bus_write_data;
    logic              r_bus_read;
    logic              r_bus_write;
    logic              r_wr_ack;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_bus_err;

    logic              w_rd_win;
    logic              w_wr_win;
    logic              w_ack_done;
    logic              w_to_done;

    // Arbitration, completion detection and next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_win    = 1'b0;
        w_wr_win    = 1'b0;
        w_ack_done  = 1'b0;
        w_to_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_rd_win = rd_req && !(wr_req && (r_rd_streak == ST_MAX));
                w_wr_win = wr_req && !w_rd_win;
                if (w_rd_win) begin
                    w_state_nxt = RD_BUSY;
                end else if (w_wr_win) begin
                    w_state_nxt = WR_BUSY;
                end
            end
            WR_BUSY, RD_BUSY: begin
                // An acknowledge in the expiry cycle still counts as success.
                w_ack_done = bus_acknowledge;
                w_to_done  = !bus_acknowledge && (r_to_cnt == TO_LAST);
                if (w_ack_done || w_to_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bridge strobes, captured address/data, counters and completion pulses.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_streak      <= '0;
            r_to_cnt         <= '0;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_read       <= 1'b0;
            r_bus_write      <= 1'b0;
            r_wr_ack         <= 1'b0;
            r_rd_valid       <= 1'b0;
            r_rd_data        <= '0;
            r_bus_err        <= 1'b0;
        end else begin
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_to_cnt <= '0;
                    // The streak only counts reads granted over a waiting write.
                    if (!wr_req) begin
                        r_rd_streak <= '0;
                    end else if (w_rd_win) begin
                        r_rd_streak <= r_rd_streak + ST_W'(1);
                    end else begin
                        r_rd_streak <= '0;
                    end
                    if (w_rd_win) begin
                        r_bus_read    <= 1'b1;
                        r_bus_address <= {rd_addr, 1'b0};
                    end else if (w_wr_win) begin
                        r_bus_write      <= 1'b1;
                        r_bus_address    <= {wr_addr, 1'b0};
                        r_bus_write_data <= wr_data;
                    end
                end
                WR_BUSY, RD_BUSY: begin
                    if (w_ack_done || w_to_done) begin
                        r_bus_read  <= 1'b0;
                        r_bus_write <= 1'b0;
                        r_to_cnt    <= '0;
                        if (r_state == RD_BUSY) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= w_ack_done ? bus_read_data : '0;
                        end else begin
                            r_wr_ack <= 1'b1;
                        end
                        if (w_to_done) begin
                            r_bus_err <= 1'b1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_ack          = r_wr_ack;
    assign rd_valid        = r_rd_valid;
    assign rd_data         = r_rd_data;
    assign bus_address     = r_bus_address;
    assign bus_byte_enable = ARB_BYTE_EN;
    assign bus_read        = r_bus_read;
    assign bus_write       = r_bus_write;
    assign bus_write_data  = r_bus_write_data;
    assign busy            = (r_state != IDLE);
    assign bus_err         = r_bus_err;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_sdram_bridge_arbiter.sv
// Randomised and directed bench for the SDRAM bridge arbiter, checked
// against a transaction-timing reference model.
module tb_sdram_bridge_arbiter;

    localparam int ADDR_W        = 25;
    localparam int DATA_W        = 16;
    localparam int MAX_RD_STREAK = 8;
    localparam int TIMEOUT_CYC   = 1024;

    logic              clk50 = 1'b0;
    logic              reset_n;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   bus_address;
    logic [1:0]        bus_byte_enable;
    logic              bus_read;
    logic              bus_write;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_acknowledge;
    logic [DATA_W-1:0] bus_read_data;
    logic              busy;
    logic              bus_err;
    sdram_arb_pkg::arb_state_t dbg_state;

    sdram_bridge_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_RD_STREAK(MAX_RD_STREAK), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk50(clk50), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
        .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
        .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
        .busy(busy), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #10 clk50 = ~clk50;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // stimulus controls
    int                req_mode = 0;  // 0 idle, 1 random, 2 both held, 3 directed
    int                resp_mode = 0; // 0 random wait 0..3, 1 fixed wait
    int                resp_fixed = 0;
    int                resp_left = -1;
    logic              ack_force = 1'b0;
    logic              rdata_fix_en = 1'b0;
    logic [DATA_W-1:0] rdata_fix = '0;
    logic              t_wr_go = 1'b0;
    logic [ADDR_W-1:0] t_wr_addr = '0;
    logic [DATA_W-1:0] t_wr_data = '0;
    logic              t_rd_go = 1'b0;
    logic [ADDR_W-1:0] t_rd_addr = '0;

    // reference model: one transaction at a time, timed by cycle arithmetic
    int                m_arb_at;   // next cycle in which the arbiter samples requests
    int                m_kind;     // 0 none, 1 read, 2 write in flight
    int                m_start;    // first strobe cycle of the in-flight transaction
    int                m_streak;   // reads granted in a row over a waiting write
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_err;
    logic              e_wr_ack, e_rd_valid, e_busy;

    // observations used by the directed checks
    int                obs_wr_cycles, obs_rd_cycles, obs_wr_acks, obs_rd_valids, obs_starts;
    logic [DATA_W-1:0] obs_last_rd;
    logic [ADDR_W:0]   obs_last_addr;
    logic              prev_rd = 1'b0, prev_wr = 1'b0;
    logic [1:0]        obs_q[$];
    logic [1:0]        exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_init();
        m_arb_at   = cyc + 1;
        m_kind     = 0;
        m_start    = 0;
        m_streak   = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_rd_data  = '0;
        m_err      = 1'b0;
        e_wr_ack   = 1'b0;
        e_rd_valid = 1'b0;
        e_busy     = 1'b0;
        resp_left  = -1;
        prev_rd    = 1'b0;
        prev_wr    = 1'b0;
    endtask

    task automatic clear_obs();
        obs_wr_cycles = 0;
        obs_rd_cycles = 0;
        obs_wr_acks   = 0;
        obs_rd_valids = 0;
        obs_starts    = 0;
        obs_last_rd   = '0;
        obs_last_addr = '0;
        obs_q.delete();
    endtask

    // compare this cycle's outputs with what the model predicted last cycle
    task automatic check_outputs();
        sdram_arb_pkg::arb_state_t exp_st;
        logic e_rd, e_wr;
        e_rd = (m_kind == 1);
        e_wr = (m_kind == 2);
        if (e_rd)                       exp_st = sdram_arb_pkg::RD_BUSY;
        else if (e_wr)                  exp_st = sdram_arb_pkg::WR_BUSY;
        else if (e_wr_ack || e_rd_valid) exp_st = sdram_arb_pkg::DONE;
        else                            exp_st = sdram_arb_pkg::IDLE;
        check_eq("ctl{rd,wr,wr_ack,rd_valid,busy,err}",
                 32'({bus_read, bus_write, wr_ack, rd_valid, busy, bus_err}),
                 32'({e_rd, e_wr, e_wr_ack, e_rd_valid, e_busy, m_err}));
        check_eq("state", 32'(dbg_state), 32'(exp_st));
        if (e_rd || e_wr) check_eq("bus_address", 32'(bus_address), 32'({m_addr, 1'b0}));
        if (e_wr) check_eq("bus_write_data", 32'(bus_write_data), 32'(m_wdata));
        check_eq("rd_data", 32'(rd_data), 32'(m_rd_data));
        check_eq("byte_en", 32'(bus_byte_enable), 32'd3);
        if (bus_write) obs_wr_cycles++;
        if (bus_read)  obs_rd_cycles++;
        if (wr_ack)    obs_wr_acks++;
        if (rd_valid) begin
            obs_rd_valids++;
            obs_last_rd = rd_data;
        end
        if (bus_read && !prev_rd) begin
            obs_starts++;
            obs_q.push_back(2'd1);
            obs_last_addr = bus_address;
        end
        if (bus_write && !prev_wr) begin
            obs_starts++;
            obs_q.push_back(2'd2);
            obs_last_addr = bus_address;
        end
        prev_rd = bus_read;
        prev_wr = bus_write;
    endtask

    // driver: bridge responder and both requesters
    task automatic drive_inputs();
        logic [31:0] r;
        if (bus_read || bus_write) begin
            if (resp_left < 0) resp_left = (resp_mode == 0) ? int'($urandom_range(0, 3)) : resp_fixed;
            bus_acknowledge = (resp_left == 0);
            resp_left = (resp_left == 0) ? -1 : resp_left - 1;
        end else begin
            resp_left = -1;
            bus_acknowledge = ack_force;
        end
        r = $urandom();
        bus_read_data = rdata_fix_en ? rdata_fix : r[DATA_W-1:0];
        case (req_mode)
            0: begin
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            1: begin
                r = $urandom();
                wr_req = (r[1:0] != 2'b00);
                rd_req = (r[3:2] != 2'b00);
                r = $urandom(); wr_addr = r[ADDR_W-1:0];
                r = $urandom(); rd_addr = r[ADDR_W-1:0];
                r = $urandom(); wr_data = r[DATA_W-1:0];
            end
            2: begin
                if (!wr_req || wr_ack) begin
                    wr_req = 1'b1;
                    r = $urandom(); wr_addr = r[ADDR_W-1:0];
                    r = $urandom(); wr_data = r[DATA_W-1:0];
                end
                if (!rd_req || rd_valid) begin
                    rd_req = 1'b1;
                    r = $urandom(); rd_addr = r[ADDR_W-1:0];
                end
            end
            default: begin
                if (wr_ack)   wr_req = 1'b0;
                if (rd_valid) rd_req = 1'b0;
                if (t_wr_go) begin
                    wr_req = 1'b1; wr_addr = t_wr_addr; wr_data = t_wr_data; t_wr_go = 1'b0;
                end
                if (t_rd_go) begin
                    rd_req = 1'b1; rd_addr = t_rd_addr; t_rd_go = 1'b0;
                end
            end
        endcase
    endtask

    // advance the reference model with the inputs applied this cycle
    task automatic model_step();
        e_wr_ack   = 1'b0;
        e_rd_valid = 1'b0;
        if (cyc == m_arb_at) begin
            if (rd_req && !(wr_req && m_streak == MAX_RD_STREAK)) begin
                m_kind   = 1;
                m_addr   = rd_addr;
                m_start  = cyc + 1;
                m_streak = wr_req ? m_streak + 1 : 0;
            end else if (wr_req) begin
                m_kind   = 2;
                m_addr   = wr_addr;
                m_wdata  = wr_data;
                m_start  = cyc + 1;
                m_streak = 0;
            end else begin
                m_streak = 0;
                m_arb_at = cyc + 1;
            end
        end else if (m_kind != 0) begin
            if (bus_acknowledge || (cyc - m_start == TIMEOUT_CYC - 1)) begin
                if (m_kind == 1) begin
                    e_rd_valid = 1'b1;
                    m_rd_data  = bus_acknowledge ? bus_read_data : '0;
                end else begin
                    e_wr_ack = 1'b1;
                end
                if (!bus_acknowledge) m_err = 1'b1;
                m_kind   = 0;
                m_arb_at = cyc + 2;
            end
        end
        e_busy = (m_arb_at != cyc + 1);
    endtask

    task automatic tick();
        @(negedge clk50);
        cyc++;
        check_outputs();
        drive_inputs();
        model_step();
    endtask

    initial begin
        wr_req = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0;
        bus_acknowledge = 0; bus_read_data = '0;
        clear_obs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk50);
        check_eq("reset_ctl", 32'({bus_read, bus_write, wr_ack, rd_valid, busy, bus_err}), 32'd0);
        check_eq("reset_addr", 32'(bus_address), 32'd0);
        check_eq("reset_wdata", 32'(bus_write_data), 32'd0);
        check_eq("reset_rd_data", 32'(rd_data), 32'd0);
        check_eq("reset_byte_en", 32'(bus_byte_enable), 32'd3);
        reset_n = 1'b1;
        model_init();
        req_mode = 0;
        repeat (3) tick();

        // single write, acknowledged in the second strobe cycle
        clear_obs();
        req_mode = 3; resp_mode = 1; resp_fixed = 1;
        t_wr_addr = 25'h000010; t_wr_data = 16'hBEEF; t_wr_go = 1'b1;
        repeat (12) tick();
        check_eq("wr_strobe_cycles", 32'(obs_wr_cycles), 32'd2);
        check_eq("wr_ack_pulses", 32'(obs_wr_acks), 32'd1);
        check_eq("wr_txn_count", 32'(obs_starts), 32'd1);
        check_eq("wr_byte_addr", 32'(obs_last_addr), 32'h20);

        // single read at the top word address
        clear_obs();
        resp_mode = 0; rdata_fix_en = 1'b1; rdata_fix = 16'h1234;
        t_rd_addr = 25'h1FFFFFF; t_rd_go = 1'b1;
        repeat (12) tick();
        rdata_fix_en = 1'b0;
        check_eq("rd_valid_pulses", 32'(obs_rd_valids), 32'd1);
        check_eq("rd_data_value", 32'(obs_last_rd), 32'h1234);
        check_eq("rd_byte_addr", 32'(obs_last_addr), 32'h3FFFFFE);
        check_eq("rd_txn_count", 32'(obs_starts), 32'd1);

        // random requests and random acknowledge latency
        req_mode = 1; resp_mode = 0;
        repeat (800) tick();
        req_mode = 0;
        repeat (8) tick();

        // both requesters held: 8 reads, 1 write, repeating
        clear_obs();
        req_mode = 2;
        for (int i = 0; i < 500 && obs_q.size() < 27; i++) tick();
        req_mode = 0;
        repeat (8) tick();
        exp_q.delete();
        for (int k = 0; k < 27; k++) exp_q.push_back((k % 9 == 8) ? 2'd2 : 2'd1);
        check_eq("starve_txn_count_ge27", 32'(obs_q.size() >= 27), 32'd1);
        for (int k = 0; k < 27; k++)
            check_eq("starve_seq", 32'((k < obs_q.size()) ? obs_q[k] : 2'd0), 32'(exp_q[k]));

        // acknowledge in the very cycle the timeout expires: no error
        clear_obs();
        req_mode = 3; resp_mode = 1; resp_fixed = TIMEOUT_CYC - 1;
        t_rd_addr = 25'h0ABCDE; t_rd_go = 1'b1;
        for (int i = 0; i < 1100 && obs_rd_valids == 0; i++) tick();
        repeat (3) tick();
        check_eq("late_ack_rd_valid", 32'(obs_rd_valids), 32'd1);
        check_eq("late_ack_no_err", 32'(bus_err), 32'd0);
        check_eq("late_ack_strobe_cycles", 32'(obs_rd_cycles), 32'(TIMEOUT_CYC));

        // no acknowledge at all: timeout
        clear_obs();
        resp_fixed = 100000;
        t_rd_addr = 25'h155555; t_rd_go = 1'b1;
        for (int i = 0; i < 1100 && obs_rd_valids == 0; i++) tick();
        check_eq("timeout_rd_valid", 32'(obs_rd_valids), 32'd1);
        check_eq("timeout_rd_data", 32'(obs_last_rd), 32'd0);
        check_eq("timeout_err", 32'(bus_err), 32'd1);
        check_eq("timeout_strobe_cycles", 32'(obs_rd_cycles), 32'(TIMEOUT_CYC));
        repeat (3) tick();

        // reset in the middle of a read
        t_rd_addr = 25'h000777; t_rd_go = 1'b1;
        repeat (5) tick();
        @(posedge clk50);
        #3;
        reset_n = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; bus_acknowledge = 1'b0;
        #1;
        check_eq("rst_mid_bus_read", 32'(bus_read), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_bus_err", 32'(bus_err), 32'd0);
        check_eq("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_mid_byte_en", 32'(bus_byte_enable), 32'd3);
        repeat (2) @(negedge clk50);
        reset_n = 1'b1;
        model_init();
        clear_obs();
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        repeat (6) tick();
        check_eq("post_rst_no_rd_valid", 32'(obs_rd_valids), 32'd0);
        check_eq("post_rst_no_txn", 32'(obs_starts), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
